// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
//
// Handshake rules:
// - CPU side: cpu_stall_o is the not-ready signal. An access presented with
//   cpu_req_i is accepted on the first rising edge where cpu_stall_o is low.
//   The pipeline holds all cpu_* inputs stable while stalled.
// - Memory side: mem_req_o acts as valid. The controller holds mem_we_o,
//   mem_addr_o and mem_data_o stable while it waits. mem_ack_i is a one-cycle
//   pulse that completes the transaction on the edge where it is sampled.
interface dcache_if #(
    parameter int LINE_W = 256
);
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    // The environment: CPU pipeline plus backing memory.
    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );

    // The cache controller.
    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits resolve combinationally in IDLE with no stall. A miss stalls the CPU,
// optionally writes back the dirty victim line, then refills the line. The
// access completes as a hit in the IDLE cycle that follows the refill.
module dcache_controller #(
    parameter int LINES  = 16,
    parameter int LINE_W = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dcache_if.slave     bus,
    output logic [1:0]  dbg_state_o,
    output logic [31:0] dbg_hit_cnt_o,
    output logic [31:0] dbg_miss_cnt_o
);
    localparam int WORDS  = LINE_W / 32;
    localparam int WSEL_W = $clog2(WORDS);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINE_W-1:0]  data_q [LINES];

    logic [31:0]        hit_cnt_q;
    logic [31:0]        miss_cnt_q;
    logic               refill_q;      // set for the one IDLE cycle after a refill
    logic [TAG_W-1:0]   miss_tag_q;
    logic [IDX_W-1:0]   miss_idx_q;

    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [LINE_W-1:0]  mem_data_q;

    logic [WSEL_W-1:0]  addr_wsel;
    logic [IDX_W-1:0]   addr_idx;
    logic [TAG_W-1:0]   addr_tag;
    logic [WSEL_W+4:0]  bit_off;
    logic [LINE_W-1:0]  sel_line;
    logic [31:0]        sel_word;
    logic               in_idle;
    logic               hit;
    logic               unused_addr_bits;

    assign addr_wsel = bus.cpu_addr_i[OFF_W-1:2];
    assign addr_idx  = bus.cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign addr_tag  = bus.cpu_addr_i[31:OFF_W+IDX_W];
    assign bit_off   = {addr_wsel, 5'b00000};
    assign sel_line  = data_q[addr_idx];
    assign sel_word  = sel_line[bit_off +: 32];
    assign in_idle   = (state_q == IDLE);

    // Byte-lane bits never select anything: accesses are whole words.
    assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

    // Tag compare, load data and stall are combinational so hits cost no cycle.
    always_comb begin
        hit = bus.cpu_req_i & valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
        bus.cpu_data_o  = (in_idle && hit && !bus.cpu_we_i) ? sel_word : 32'd0;
        bus.cpu_stall_o = !in_idle || (bus.cpu_req_i && !hit);
    end

    assign bus.mem_req_o  = mem_req_q;
    assign bus.mem_we_o   = mem_we_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_data_o = mem_data_q;

    assign dbg_state_o    = state_q;
    assign dbg_hit_cnt_o  = hit_cnt_q;
    assign dbg_miss_cnt_o = miss_cnt_q;

    // Controller FSM: line arrays, counters and registered memory-side outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            refill_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    refill_q <= 1'b0;
                    if (bus.cpu_req_i) begin
                        if (hit) begin
                            // The hit that finishes a refilled miss was already counted as a miss.
                            if (!refill_q) begin
                                hit_cnt_q <= hit_cnt_q + 32'd1;
                            end
                            if (bus.cpu_we_i) begin
                                data_q[addr_idx][bit_off +: 32] <= bus.cpu_data_i;
                                dirty_q[addr_idx] <= 1'b1;
                            end
                        end else begin
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                            miss_tag_q <= addr_tag;
                            miss_idx_q <= addr_idx;
                            mem_req_q  <= 1'b1;
                            if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                                state_q    <= WRITEBACK;
                                mem_we_q   <= 1'b1;
                                mem_addr_q <= {tag_q[addr_idx], addr_idx, {OFF_W{1'b0}}};
                                mem_data_q <= data_q[addr_idx];
                            end else begin
                                state_q    <= ALLOCATE;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= {addr_tag, addr_idx, {OFF_W{1'b0}}};
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        state_q    <= ALLOCATE;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ack_i) begin
                        data_q[miss_idx_q]  <= bus.mem_data_i;
                        tag_q[miss_idx_q]   <= miss_tag_q;
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                        mem_req_q <= 1'b0;
                        refill_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios then random accesses, all
// checked against a memory-level reference (golden CPU view plus backing store).
module tb_dcache_controller;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_AL   = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dbg_state;
    logic [31:0] dbg_hit;
    logic [31:0] dbg_miss;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: gold is what the CPU must observe, bmem is backing memory.
    logic [31:0] gold [int unsigned];
    logic [31:0] bmem [int unsigned];
    bit          m_valid [16];
    bit          m_dirty [16];
    int unsigned m_tag   [16];
    logic [31:0] m_hit;
    logic [31:0] m_miss;

    dcache_if #(.LINE_W(256)) bus ();

    dcache_controller #(.LINES(16), .LINE_W(256)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus.slave),
        .dbg_state_o    (dbg_state),
        .dbg_hit_cnt_o  (dbg_hit),
        .dbg_miss_cnt_o (dbg_miss)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic touch(input int unsigned wa);
        if (!bmem.exists(wa)) bmem[wa] = $urandom;
        if (!gold.exists(wa)) gold[wa] = bmem[wa];
    endtask

    function automatic logic [255:0] gold_line(input int unsigned blk);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold[blk*8 + w];
        return l;
    endfunction

    function automatic logic [255:0] bmem_line(input int unsigned blk);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = bmem[blk*8 + w];
        return l;
    endfunction

    function automatic logic [31:0] mk_addr(input int unsigned tg, input int unsigned idx, input int unsigned w);
        return 32'((tg << 9) | (idx << 5) | (w << 2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end
        m_hit  = 32'd0;
        m_miss = 32'd0;
        gold   = bmem;   // un-written-back stores are lost on reset
    endtask

    // One memory transaction: outputs checked every wait cycle, ack after dly cycles.
    task automatic mem_phase(input string tag, input logic [1:0] st, input bit we,
                             input logic [31:0] addr, input bit chk_d,
                             input logic [255:0] exp_d, input logic [255:0] rdata, input int dly);
        for (int i = 0; i <= dly; i++) begin
            chk({tag, "_state"}, 256'(dbg_state), 256'(st));
            chk({tag, "_req"},   256'(bus.mem_req_o), 256'(1'b1));
            chk({tag, "_we"},    256'(bus.mem_we_o), 256'(we));
            chk({tag, "_addr"},  256'(bus.mem_addr_o), 256'(addr));
            chk({tag, "_stall"}, 256'(bus.cpu_stall_o), 256'(1'b1));
            if (chk_d) chk({tag, "_data"}, bus.mem_data_o, exp_d);
            if (i == dly) begin
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = rdata;
            end
            @(posedge clk); #1;
        end
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
    endtask

    // Driver: one CPU access, from presentation to acceptance.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int dly);
        int unsigned wa  = int'(addr >> 2);
        int unsigned blk = int'(addr >> 5);
        int unsigned idx = blk % 16;
        int unsigned tg  = int'(addr >> 9);
        bit          hit = m_valid[idx] && (m_tag[idx] == tg);
        for (int w = 0; w < 8; w++) touch(blk*8 + w);
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = we;
        bus.cpu_addr_i = addr;
        bus.cpu_data_i = wdata;
        #1;
        if (hit) begin
            chk("hit_stall", 256'(bus.cpu_stall_o), 256'(1'b0));
            chk(we ? "store_data_zero" : "hit_data", 256'(bus.cpu_data_o), we ? 256'(0) : 256'(gold[wa]));
            m_hit++;
            @(posedge clk); #1;
        end else begin
            chk("miss_stall", 256'(bus.cpu_stall_o), 256'(1'b1));
            chk("miss_data_zero", 256'(bus.cpu_data_o), 256'(0));
            m_miss++;
            @(posedge clk); #1;
            if (m_valid[idx] && m_dirty[idx]) begin
                int unsigned vblk = m_tag[idx]*16 + idx;
                mem_phase("wb", ST_WB, 1'b1, 32'(vblk << 5), 1'b1, gold_line(vblk), '0, dly);
                for (int w = 0; w < 8; w++) bmem[vblk*8 + w] = gold[vblk*8 + w];
            end
            mem_phase("alloc", ST_AL, 1'b0, 32'(blk << 5), 1'b0, '0, bmem_line(blk), dly);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            chk("refill_state", 256'(dbg_state), 256'(ST_IDLE));
            chk("refill_stall", 256'(bus.cpu_stall_o), 256'(1'b0));
            if (!we) chk("refill_data", 256'(bus.cpu_data_o), 256'(gold[wa]));
            @(posedge clk); #1;
        end
        if (we) begin
            gold[wa]     = wdata;
            m_dirty[idx] = 1'b1;
        end
        bus.cpu_req_i = 1'b0;
        chk("hit_cnt", 256'(dbg_hit), 256'(m_hit));
        chk("miss_cnt", 256'(dbg_miss), 256'(m_miss));
    endtask

    initial begin
        rst            = 1'b1;
        bus.cpu_req_i  = 1'b0;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = '0;
        bus.cpu_data_i = '0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 256'(dbg_state), 256'(ST_IDLE));
        chk("rst_mem_req", 256'(bus.mem_req_o), 256'(1'b0));
        chk("rst_mem_we", 256'(bus.mem_we_o), 256'(1'b0));
        chk("rst_stall", 256'(bus.cpu_stall_o), 256'(1'b0));
        chk("rst_data", 256'(bus.cpu_data_o), 256'(0));
        chk("rst_hit_cnt", 256'(dbg_hit), 256'(0));
        chk("rst_miss_cnt", 256'(dbg_miss), 256'(0));
        rst = 1'b0;

        // Cold read, then a zero-latency hit returning a known word
        bmem[32'h48 >> 2] = 32'hDEAD_BEEF;
        access(1'b0, 32'h0000_0040, 32'd0, 2);
        access(1'b0, 32'h0000_0048, 32'd0, 0);
        chk("cold_word2", 256'(gold[32'h48 >> 2]), 256'(32'hDEAD_BEEF));
        chk("cold_miss_cnt", 256'(dbg_miss), 256'(1));

        // Store hit makes the line dirty; read back
        access(1'b1, 32'h0000_0044, 32'h1234_5678, 0);
        access(1'b0, 32'h0000_0044, 32'd0, 0);

        // Dirty conflict: writeback to 0x40 then allocate 0x240
        access(1'b0, 32'h0000_0240, 32'd0, 1);
        // Clean conflict: allocate only
        access(1'b0, 32'h0000_0440, 32'd0, 0);

        // Reset while allocating; late ack must be ignored
        touch(32'h640 >> 2);
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0640;
        @(posedge clk); #1;
        chk("rstal_state", 256'(dbg_state), 256'(ST_AL));
        bus.cpu_req_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        chk("rstal_idle", 256'(dbg_state), 256'(ST_IDLE));
        chk("rstal_mem_req", 256'(bus.mem_req_o), 256'(1'b0));
        chk("rstal_mem_we", 256'(bus.mem_we_o), 256'(1'b0));
        chk("rstal_stall", 256'(bus.cpu_stall_o), 256'(1'b0));
        chk("rstal_data", 256'(bus.cpu_data_o), 256'(0));
        chk("rstal_miss_cnt", 256'(dbg_miss), 256'(0));
        model_reset();
        access(1'b0, 32'h0000_0440, 32'd0, 0);
        access(1'b0, 32'h0000_0048, 32'd0, 0);

        // Random traffic over a few indices to force conflicts
        for (int i = 0; i < 150; i++) begin
            bit          we  = 1'($urandom_range(0, 1));
            logic [31:0] a   = mk_addr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
            int          dly = (i == 20) ? 10 : int'($urandom_range(0, 3));
            if (i == 20) begin
                // Force a dirty writeback with the long ack delay
                access(1'b1, mk_addr(0, 5, 1), $urandom, 0);
                a  = mk_addr(1, 5, 3);
                we = 1'b0;
            end
            access(we, a, $urandom, dly);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
